// File: rtl/afu_fifo_pkg.sv
// Shared sizing constants and types for the AFU MMIO FIFO buffer.
// Width/depth defaults and the occupancy-counter type live here.
package afu_fifo_pkg;

    localparam int FIFO_WIDTH = 64;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef logic [FIFO_CNT_W-1:0] t_fifo_cnt;

endpackage

// File: rtl/fifo_mem_2p.sv
// Register-array storage: one write port, one registered read port.
// Only the read register is reset; the array itself is not.
module fifo_mem_2p #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: same-address push and pop return the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mmio_fifo_buf.sv
// MMIO-facing FIFO: push/pop decode, pointers, occupancy and sticky errors.
// Storage sits in fifo_mem_2p; rd_data is its registered read port.
module mmio_fifo_buf
    import afu_fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    input  logic                   clr_err,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = rd_en && !empty;
    assign push_ok = wr_en && (!full || pop_ok);

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok && !rst),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (pop_ok && !rst),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
            // A same-cycle error event outranks the clear.
            if (wr_en && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && !pop_ok) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmio_fifo_buf.sv
// Bench for mmio_fifo_buf: vector table, directed corners, random traffic.
// Expected values come from a queue-based reference model.
module tb_mmio_fifo_buf;
    import afu_fifo_pkg::*;

    localparam int W = FIFO_WIDTH;
    localparam int D = FIFO_DEPTH;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            wr_en = 1'b0;
    logic [W-1:0]    wr_data = '0;
    logic            rd_en = 1'b0;
    logic            clr_err = 1'b0;
    logic [W-1:0]    rd_data;
    logic            rd_valid;
    logic            full;
    logic            empty;
    t_fifo_cnt       count;
    logic            overflow;
    logic            underflow;

    mmio_fifo_buf dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of entries plus observed output state.
    logic [W-1:0] q[$];
    logic [W-1:0] m_rd;
    logic         m_valid;
    logic         m_ovf;
    logic         m_unf;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic w, input logic [W-1:0] wd,
                              input logic rd, input logic c);
        bit pop_ok;
        bit push_ok;
        if (r) begin
            q.delete();
            m_rd = '0;
            m_valid = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pop_ok = rd && (q.size() > 0);
            push_ok = w && ((q.size() < D) || pop_ok);
            m_valid = pop_ok;
            if (pop_ok) m_rd = q.pop_front();
            if (push_ok) q.push_back(wd);
            if (w && !push_ok) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            if (rd && !pop_ok) m_unf = 1'b1;
            else if (c) m_unf = 1'b0;
        end
    endtask

    task automatic check_model();
        check("rd_data", rd_data, m_rd);
        check("rd_valid", W'(rd_valid), W'(m_valid));
        check("count", W'(count), W'(q.size()));
        check("full", W'(full), W'(q.size() == D));
        check("empty", W'(empty), W'(q.size() == 0));
        check("overflow", W'(overflow), W'(m_ovf));
        check("underflow", W'(underflow), W'(m_unf));
    endtask

    task automatic step(input logic r, input logic w, input logic [W-1:0] wd,
                        input logic rd, input logic c);
        rst = r;
        wr_en = w;
        wr_data = wd;
        rd_en = rd;
        clr_err = c;
        @(posedge clk);
        #1;
        model_step(r, w, wd, rd, c);
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr_err = 1'b0;
        check_model();
    endtask

    typedef struct {
        logic         r;
        logic         w;
        logic [W-1:0] wd;
        logic         rd;
        logic         c;
        logic         ev;
        logic [W-1:0] erd;
        int           ecnt;
        logic         eo;
        logic         eu;
    } vec_t;

    vec_t tbl[13];
    logic [W-1:0] vals[D];
    logic [W-1:0] first;

    initial begin
        tbl[0]  = '{1, 0, 0,     0, 0, 0, 0,     0, 0, 0};
        tbl[1]  = '{0, 1, 'h11,  0, 0, 0, 0,     1, 0, 0};
        tbl[2]  = '{0, 1, 'h22,  0, 0, 0, 0,     2, 0, 0};
        tbl[3]  = '{0, 1, 'h33,  0, 0, 0, 0,     3, 0, 0};
        tbl[4]  = '{0, 0, 0,     1, 0, 1, 'h11,  2, 0, 0};
        tbl[5]  = '{0, 0, 0,     1, 0, 1, 'h22,  1, 0, 0};
        tbl[6]  = '{0, 0, 0,     1, 0, 1, 'h33,  0, 0, 0};
        tbl[7]  = '{0, 0, 0,     0, 0, 0, 'h33,  0, 0, 0};
        tbl[8]  = '{0, 0, 0,     1, 0, 0, 'h33,  0, 0, 1};
        tbl[9]  = '{0, 0, 0,     0, 1, 0, 'h33,  0, 0, 0};
        tbl[10] = '{0, 1, 'h44,  1, 0, 0, 'h33,  1, 0, 1};
        tbl[11] = '{0, 0, 0,     1, 1, 1, 'h44,  0, 0, 0};
        tbl[12] = '{0, 0, 0,     1, 1, 0, 'h44,  0, 0, 1};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].wd, tbl[i].rd, tbl[i].c);
            check($sformatf("tbl%0d_valid", i), W'(rd_valid), W'(tbl[i].ev));
            check($sformatf("tbl%0d_rd", i), rd_data, tbl[i].erd);
            check($sformatf("tbl%0d_cnt", i), W'(count), W'(tbl[i].ecnt));
            check($sformatf("tbl%0d_ovf", i), W'(overflow), W'(tbl[i].eo));
            check($sformatf("tbl%0d_unf", i), W'(underflow), W'(tbl[i].eu));
        end

        // Fill, then a dropped ninth push.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < D; i++) begin
            vals[i] = W'(64'h1000 + i * 3);
            step(0, 1, vals[i], 0, 0);
        end
        step(0, 1, 'hDEAD, 0, 0);
        check("ovf_full", W'(full), 1);
        check("ovf_flag", W'(overflow), 1);
        check("ovf_count", W'(count), D);
        for (int i = 0; i < D; i++) begin
            step(0, 0, 0, 1, 0);
            check("ovf_pop", rd_data, vals[i]);
        end
        check("ovf_drain", W'(empty), 1);

        // Simultaneous push/pop while full.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < D; i++) step(0, 1, W'(64'h500 + i), 0, 0);
        step(0, 1, 'hAA, 1, 0);
        check("fullpp_rd", rd_data, 'h500);
        check("fullpp_cnt", W'(count), D);
        check("fullpp_ovf", W'(overflow), 0);
        for (int i = 0; i < D; i++) step(0, 0, 0, 1, 0);
        check("fullpp_last", rd_data, 'hAA);

        // Pointer wrap with push/pop pairs.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, W'(64'hC00 + i), 0, 0);
            step(0, 0, 0, 1, 0);
            check("wrap_rd", rd_data, W'(64'hC00 + i));
        end
        check("wrap_cnt", W'(count), 0);

        // Reset mid-operation with flags set and requests active.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < D + 1; i++) step(0, 1, W'(i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check("pre_rst_cnt", W'(count), 5);
        step(1, 1, 'h77, 1, 0);
        check("rst_cnt", W'(count), 0);
        check("rst_empty", W'(empty), 1);
        check("rst_valid", W'(rd_valid), 0);
        check("rst_flags", W'({overflow, underflow}), 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step(r < 2, $urandom_range(0, 99) < 55, {$urandom, $urandom},
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
